// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: lane count, select width,
// arbiter state encoding and the rotating priority search.
package rr_mux_arbiter_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned SEL_W     = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First set bit of req, searching upward from ptr+1 and wrapping modulo 4.
  function automatic pick_t rr_pick(input logic [NUM_LANES-1:0] req,
                                    input logic [SEL_W-1:0]     ptr);
    pick_t            res;
    logic [SEL_W-1:0] cand;
    res = '0;
    for (int unsigned k = 1; k <= NUM_LANES; k++) begin
      cand = ptr + k[SEL_W-1:0];
      if (!res.found && req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux4to1.sv
// Single-bit 4:1 multiplexer; one instance per data bit of the shared channel.
module mux4to1 (
  input  logic [3:0] w,
  input  logic [1:0] s,
  output logic       f
);

  // Steer the selected lane bit to the output.
  always_comb begin
    f = w[s];
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux channel among four requesters, with
// a hold limit that bounds how long one lane keeps the channel under contention.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int unsigned DW       = 1,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_LANES-1:0]    req,
  input  logic [NUM_LANES*DW-1:0] din,
  output logic [NUM_LANES-1:0]    gnt,
  output logic [SEL_W-1:0]        sel,
  output logic [DW-1:0]           dout,
  output logic                    dout_valid
);

  localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  state_t               r_state,    w_state_nxt;
  logic [NUM_LANES-1:0] r_gnt,      w_gnt_nxt;
  logic [SEL_W-1:0]     r_sel,      w_sel_nxt;
  logic                 r_dv,       w_dv_nxt;
  logic [SEL_W-1:0]     r_last_ptr, w_last_nxt;
  logic [HW-1:0]        r_hold,     w_hold_nxt;

  logic [NUM_LANES-1:0] w_others;
  pick_t                w_pick_idle;
  pick_t                w_pick_next;
  logic [DW-1:0]        w_mux;

  // The current owner is exactly the set gnt bit, so masking it off yields the
  // competing requests.
  always_comb begin
    w_others    = req & ~r_gnt;
    w_pick_idle = rr_pick(req, r_last_ptr);
    w_pick_next = rr_pick(w_others, r_sel);
  end

  // Next-state, grant, pointer and hold-counter decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_dv_nxt    = r_dv;
    w_last_nxt  = r_last_ptr;
    w_hold_nxt  = r_hold;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_state_nxt                 = ST_BUSY;
          w_gnt_nxt                   = '0;
          w_gnt_nxt[w_pick_idle.idx]  = 1'b1;
          w_sel_nxt                   = w_pick_idle.idx;
          w_dv_nxt                    = 1'b1;
          w_hold_nxt                  = '0;
        end
      end
      ST_BUSY: begin
        // Release takes precedence over preempt; both hand over from owner+1.
        if (!req[r_sel] || ((r_hold == HOLD_LAST) && (|w_others))) begin
          w_last_nxt = r_sel;
          w_hold_nxt = '0;
          if (w_pick_next.found) begin
            w_gnt_nxt                  = '0;
            w_gnt_nxt[w_pick_next.idx] = 1'b1;
            w_sel_nxt                  = w_pick_next.idx;
          end else begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
            w_dv_nxt    = 1'b0;
          end
        end else if (|w_others) begin
          w_hold_nxt = (r_hold == HOLD_LAST) ? r_hold : r_hold + 1'b1;
        end else begin
          w_hold_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
        w_dv_nxt    = 1'b0;
        w_hold_nxt  = '0;
      end
    endcase
  end

  // Arbiter state register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_sel      <= '0;
      r_dv       <= 1'b0;
      r_last_ptr <= '1;
      r_hold     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_sel      <= w_sel_nxt;
      r_dv       <= w_dv_nxt;
      r_last_ptr <= w_last_nxt;
      r_hold     <= w_hold_nxt;
    end
  end

  genvar gb;
  generate
    for (gb = 0; gb < DW; gb++) begin : g_bit
      mux4to1 u_mux (
        .w ({din[3*DW+gb], din[2*DW+gb], din[DW+gb], din[gb]}),
        .s (r_sel),
        .f (w_mux[gb])
      );
    end
  endgenerate

  // Output channel is forced to zero while no lane holds the grant.
  always_comb begin
    gnt        = r_gnt;
    sel        = r_sel;
    dout_valid = r_dv;
    dout       = r_dv ? w_mux : '0;
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;

  localparam int DW = 2;
  localparam int MH = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      req;
  logic [4*DW-1:0] din;
  logic [3:0]      gnt;
  logic [1:0]      sel;
  logic [DW-1:0]   dout;
  logic            dout_valid;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.DW(DW), .MAX_HOLD(MH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .din        (din),
    .gnt        (gnt),
    .sel        (sel),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  // Model: owner lane as an integer (-1 = nobody), last served lane, and the
  // number of consecutive contended cycles the owner has already used.
  typedef struct {
    int owner;
    int last;
    int run;
  } mstate_t;

  mstate_t m;

  function automatic int search(int from, logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  function automatic mstate_t step(mstate_t s, logic [3:0] r);
    mstate_t n;
    bit      contended;
    n = s;
    if (s.owner < 0) begin
      if (r != 4'b0000) begin
        n.owner = search(s.last, r);
        n.run   = 0;
      end
    end else begin
      contended = 1'b0;
      for (int i = 0; i < 4; i++) if (i != s.owner && r[i]) contended = 1'b1;
      if (!r[s.owner] || (s.run == MH - 1 && contended)) begin
        n.last  = s.owner;
        n.owner = search(s.owner, r);
        n.run   = 0;
      end else if (contended) begin
        n.run = (s.run + 1 > MH - 1) ? MH - 1 : s.run + 1;
      end else begin
        n.run = 0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{owner: -1, last: 3, run: 0};
    else        m <= step(m, req);
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (m.owner < 0) begin
        chk("model_gnt", {28'b0, gnt}, 32'h0);
        chk("model_dv", {31'b0, dout_valid}, 32'h0);
        chk("model_dout", {30'b0, dout}, 32'h0);
      end else begin
        chk("model_gnt", {28'b0, gnt}, 32'h1 << m.owner);
        chk("model_sel", {30'b0, sel}, m.owner);
        chk("model_dv", {31'b0, dout_valid}, 32'h1);
        chk("model_dout", {30'b0, dout}, {30'b0, din[m.owner*DW +: DW]});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    din   = 8'hFF;
    #2;
    // Reset: outputs clear with no clock edge.
    chk("rst_gnt", {28'b0, gnt}, 32'h0);
    chk("rst_sel", {30'b0, sel}, 32'h0);
    chk("rst_dv", {31'b0, dout_valid}, 32'h0);
    chk("rst_dout", {30'b0, dout}, 32'h0);
    tick;
    tick;
    chk("rst_hold_gnt", {28'b0, gnt}, 32'h0);
    rst_n = 1'b1;
    tick;
    chk("first_gnt", {28'b0, gnt}, 32'h1);

    // Fairness: each lane keeps the channel for exactly MAX_HOLD cycles.
    for (int k = 1; k < 20; k++) begin
      din = 8'($urandom);
      tick;
      chk("fair_gnt", {28'b0, gnt}, 32'h1 << ((k / 4) % 4));
    end
    req = 4'b0000;
    tick;
    chk("idle_gnt", {28'b0, gnt}, 32'h0);
    chk("idle_dv", {31'b0, dout_valid}, 32'h0);

    // Single request on lane 2.
    req = 4'b0100;
    din = 8'h10;
    tick;
    chk("single_gnt", {28'b0, gnt}, 32'h4);
    chk("single_sel", {30'b0, sel}, 32'h2);
    chk("single_dout", {30'b0, dout}, 32'h1);
    req = 4'b0000;
    tick;
    chk("drop_gnt", {28'b0, gnt}, 32'h0);
    chk("drop_dv", {31'b0, dout_valid}, 32'h0);
    chk("drop_dout", {30'b0, dout}, 32'h0);

    // No contention: hold count must not advance.
    req = 4'b0001;
    tick;
    chk("solo_gnt", {28'b0, gnt}, 32'h1);
    for (int k = 0; k < 10; k++) begin
      din = 8'($urandom);
      tick;
      chk("solo_hold", {28'b0, gnt}, 32'h1);
    end
    req = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("contend_keep", {28'b0, gnt}, 32'h1);
    end
    tick;
    chk("contend_switch", {28'b0, gnt}, 32'h2);

    // Back-to-back release from lane 1 to lane 3.
    req = 4'b1010;
    tick;
    chk("b2b_pre", {28'b0, gnt}, 32'h2);
    req = 4'b1000;
    tick;
    chk("b2b_gnt", {28'b0, gnt}, 32'h8);
    chk("b2b_dv", {31'b0, dout_valid}, 32'h1);

    // Reset mid-grant on lane 3; pointer restarts at lane 0.
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt", {28'b0, gnt}, 32'h0);
    chk("midrst_dv", {31'b0, dout_valid}, 32'h0);
    chk("midrst_dout", {30'b0, dout}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = 4'b1001;
    tick;
    chk("midrst_win", {28'b0, gnt}, 32'h1);

    // Random traffic, checked by the model compare process.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      din = 8'($urandom);
      tick;
    end
    req = 4'b0000;
    tick;
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
